// File: rtl/sync_fifo_pkg.sv
// Shared FIFO definitions: default geometry, operation encoding and the
// power-of-two depth check used by the FIFOs in this design.
package sync_fifo_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_DEPTH = 16;

    // Accepted operations in one cycle, encoded as {write_ok, read_ok}.
    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_BOTH  = 2'b11
    } fifo_op_e;

    function automatic bit is_pow2(input int unsigned n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x WIDTH storage with one synchronous write port and one registered
// read port; the read register is resettable, the array is not.
module fifo_ram
    import sync_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_re,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    // Read-before-write: a same-address read in the write cycle returns the old word.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rdata_q <= '0;
        end else if (i_re) begin
            rdata_q <= mem_q[i_raddr];
        end
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock byte FIFO: pointers, occupancy, flags and sticky error bits
// around a fifo_ram instance with a registered read port.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_we,
    input  logic [WIDTH-1:0]         i_data,
    output logic                     o_full,
    input  logic                     i_re,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_valid,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow,
    output logic                     o_underflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    generate
        if (!is_pow2(DEPTH)) begin : g_depth_check
            $error("sync_fifo: DEPTH must be a power of two and >= 2");
        end
    endgenerate

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          valid_q, valid_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          wr_ok, rd_ok;
    fifo_op_e      op;

    always_comb begin
        rd_ok    = i_re && !empty_q;
        // A read in the same cycle frees the slot, so a full FIFO still accepts the write.
        wr_ok    = i_we && (!full_q || rd_ok);
        op       = fifo_op_e'({wr_ok, rd_ok});

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        case (op)
            OP_WRITE: begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                count_d  = count_q + CW'(1);
            end
            OP_READ: begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                count_d  = count_q - CW'(1);
            end
            OP_BOTH: begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            default: ;
        endcase

        full_d   = (count_d == CW'(DEPTH));
        empty_d  = (count_d == '0);
        valid_d  = rd_ok;
        ovf_d    = ovf_q || (i_we && full_q && !rd_ok);
        unf_d    = unf_q || (i_re && empty_q);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_we    (wr_ok && !i_reset),
        .i_waddr (wr_ptr_q),
        .i_wdata (i_data),
        .i_re    (rd_ok && !i_reset),
        .i_raddr (rd_ptr_q),
        .o_rdata (o_data)
    );

    assign o_full      = full_q;
    assign o_empty     = empty_q;
    assign o_count     = count_q;
    assign o_valid     = valid_q;
    assign o_overflow  = ovf_q;
    assign o_underflow = unf_q;

`ifdef FORMAL
    logic seen_full_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            seen_full_q <= 1'b0;
        end else if (full_q) begin
            seen_full_q <= 1'b1;
        end
    end

    always_comb begin
        assert (count_q <= CW'(DEPTH));
        assert (full_q == (count_q == CW'(DEPTH)));
        assert (empty_q == (count_q == '0));
        assert (AW'(wr_ptr_q - rd_ptr_q) == count_q[AW-1:0]);
        cover (seen_full_q && empty_q);
    end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: stimulus pushes expected read words into a
// scoreboard queue, a negedge monitor pops and compares on every o_valid.
module tb_sync_fifo;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             we;
    logic [WIDTH-1:0] wdata;
    logic             re;
    logic             full, valid, empty, ovf, unf;
    logic [WIDTH-1:0] rdata;
    logic [4:0]       count;

    int unsigned cyc = 0;
    int unsigned total = 0;
    int unsigned passed = 0;

    typedef struct {
        logic [WIDTH-1:0] data;
        int unsigned      stamp;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_we        (we),
        .i_data      (wdata),
        .o_full      (full),
        .i_re        (re),
        .o_data      (rdata),
        .o_valid     (valid),
        .o_empty     (empty),
        .o_count     (count),
        .o_overflow  (ovf),
        .o_underflow (unf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every expected word must appear exactly at its stamped cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].stamp < cyc) begin
            check("read_missing", cyc, sb[0].stamp);
            void'(sb.pop_front());
        end
        if (valid) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", valid, 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rd_data", rdata, e.data);
                check("rd_latency", cyc, e.stamp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic wr(input logic [WIDTH-1:0] d);
        we = 1'b1;
        wdata = d;
        tick();
        we = 1'b0;
    endtask

    task automatic rd(input logic [WIDTH-1:0] d);
        exp_t e;
        e.data = d;
        e.stamp = cyc + 1;
        sb.push_back(e);
        re = 1'b1;
        tick();
        re = 1'b0;
    endtask

    task automatic check_status(input string tag, input logic [4:0] c, input logic f,
                                input logic em, input logic ov, input logic un);
        check({tag, "_count"}, count, c);
        check({tag, "_full"}, full, f);
        check({tag, "_empty"}, empty, em);
        check({tag, "_overflow"}, ovf, ov);
        check({tag, "_underflow"}, unf, un);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        we = 1'b0;
        re = 1'b0;
        wdata = '0;
        tick();
        reset = 1'b0;

        // 1: reset state
        check_status("reset", 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("reset_valid", valid, 1'b0);
        check("reset_data", rdata, 8'h00);

        // 2: three writes, three reads
        wr(8'h11); wr(8'h22); wr(8'h33);
        check_status("three", 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        rd(8'h11); rd(8'h22); rd(8'h33);
        tick();
        check_status("drain3", 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("hold_valid", valid, 1'b0);
        check("hold_data", rdata, 8'h33);

        // 3: fill, overflow, drain; second fill exercises pointer wrap
        for (int i = 0; i < 16; i++) wr(WIDTH'(i));
        check_status("fill", 5'd16, 1'b1, 1'b0, 1'b0, 1'b0);
        wr(8'hAA);
        check_status("ovf", 5'd16, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) rd(WIDTH'(i));
        tick();
        check_status("drain16", 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) wr(WIDTH'(8'h10 + i));
        check("wrap_count", count, 5'd16);
        for (int i = 0; i < 16; i++) rd(WIDTH'(8'h10 + i));
        tick();
        check("wrap_empty", empty, 1'b1);

        // 4: simultaneous read+write while full
        do_reset();
        for (int i = 0; i < 16; i++) wr(WIDTH'(8'h20 + i));
        begin
            exp_t e;
            e.data = 8'h20;
            e.stamp = cyc + 1;
            sb.push_back(e);
        end
        we = 1'b1; re = 1'b1; wdata = 8'h55;
        tick();
        we = 1'b0; re = 1'b0;
        check_status("fullrw", 5'd16, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i < 16; i++) rd(WIDTH'(8'h20 + i));
        rd(8'h55);
        tick();
        check("fullrw_empty", empty, 1'b1);

        // 5: simultaneous read+write while empty: no fall-through
        we = 1'b1; re = 1'b1; wdata = 8'h77;
        tick();
        we = 1'b0; re = 1'b0;
        check_status("emptyrw", 5'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("emptyrw_valid", valid, 1'b0);
        rd(8'h77);
        tick();
        check("emptyrw_drain", count, 5'd0);

        // 6: reset mid-operation, with strobes asserted in the reset cycle
        for (int i = 0; i < 5; i++) wr(WIDTH'(8'h60 + i));
        check("pre_reset_count", count, 5'd5);
        reset = 1'b1; we = 1'b1; re = 1'b1; wdata = 8'hEE;
        tick();
        reset = 1'b0; we = 1'b0; re = 1'b0;
        check_status("midreset", 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("midreset_valid", valid, 1'b0);
        check("midreset_data", rdata, 8'h00);
        wr(8'h99);
        check("post_reset_count", count, 5'd1);
        rd(8'h99);
        tick();
        tick();

        check("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
